// File: rtl/board_pkg.sv
// Board geometry and turn FSM encoding shared by the turn manager and the movement block.
package board_pkg;
    typedef enum logic [2:0] {
        IDLE,
        CALC,
        ISSUE,
        WAIT_DONE,
        CHECK,
        GAME_OVER
    } state_t;

    localparam int START_X      = 20;
    localparam int TILE_SPACING = 60;
    localparam int NUM_TILES    = 10;
    localparam int FLAG_X       = START_X + TILE_SPACING * NUM_TILES;

    // Pixel x of a tile index; the board never exceeds 10 bits of x.
    function automatic logic [9:0] tile_to_x(input int start_x, input int spacing,
                                             input logic [4:0] tile);
        return 10'(start_x + spacing * int'(tile));
    endfunction
endpackage

// File: rtl/rise_edge_detect.sv
// Registered rising-edge detector: pulses for the first cycle din is seen high.
module rise_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev <= 1'b0;
        else     prev <= din;
    end

    assign rise = din & ~prev;
endmodule

// File: rtl/turn_manager.sv
// Two-player board-game turn sequencer: dice roll -> target x -> move request -> commit.
module turn_manager #(
    parameter int START_X        = board_pkg::START_X,
    parameter int TILE_SPACING   = board_pkg::TILE_SPACING,
    parameter int NUM_TILES      = board_pkg::NUM_TILES,
    parameter int TIMEOUT_CYCLES = 2**22
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       roll_btn,
    input  logic [2:0] dice_value,
    input  logic       p1_turn_done,
    input  logic       p2_turn_done,
    output logic [9:0] p1_target_x,
    output logic [9:0] p2_target_x,
    output logic       p1_move_start,
    output logic       p2_move_start,
    output logic [3:0] p1_tile,
    output logic [3:0] p2_tile,
    output logic       current_player,
    output logic       busy,
    output logic       winner_valid,
    output logic       winner_id,
    output logic       err_timeout,
    output logic       err_bad_dice
);
    import board_pkg::*;

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t          state;
    logic            roll_edge;
    logic [2:0]      dice_q;
    logic [3:0]      pend_tile;
    logic [TW-1:0]   tmo_cnt;
    logic [3:0]      cur_tile;
    logic [4:0]      sum_tile;
    logic [4:0]      new_tile;
    logic [9:0]      new_x;
    logic            cur_done;
    logic            dice_ok;

    rise_edge_detect u_roll_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (roll_btn),
        .rise (roll_edge)
    );

    // Sum is kept 5 bits wide so a roll from tile 9 cannot wrap before the clamp.
    assign cur_tile = current_player ? p2_tile : p1_tile;
    assign sum_tile = {1'b0, cur_tile} + {2'b00, dice_q};
    assign new_tile = (sum_tile > 5'(NUM_TILES)) ? 5'(NUM_TILES) : sum_tile;
    assign new_x    = tile_to_x(START_X, TILE_SPACING, new_tile);
    assign cur_done = current_player ? p2_turn_done : p1_turn_done;
    assign dice_ok  = (dice_value != 3'd0) && (dice_value != 3'd7);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            current_player <= 1'b0;
            dice_q         <= '0;
            pend_tile      <= '0;
            tmo_cnt        <= '0;
            p1_tile        <= '0;
            p2_tile        <= '0;
            p1_target_x    <= 10'(START_X);
            p2_target_x    <= 10'(START_X);
            p1_move_start  <= 1'b0;
            p2_move_start  <= 1'b0;
            winner_valid   <= 1'b0;
            winner_id      <= 1'b0;
            err_timeout    <= 1'b0;
            err_bad_dice   <= 1'b0;
        end else begin
            p1_move_start <= 1'b0;
            p2_move_start <= 1'b0;
            err_bad_dice  <= 1'b0;
            case (state)
                IDLE: begin
                    if (roll_edge) begin
                        if (dice_ok) begin
                            dice_q <= dice_value;
                            state  <= CALC;
                        end else begin
                            err_bad_dice <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    pend_tile <= new_tile[3:0];
                    if (current_player) begin
                        p2_target_x   <= new_x;
                        p2_move_start <= 1'b1;
                    end else begin
                        p1_target_x   <= new_x;
                        p1_move_start <= 1'b1;
                    end
                    state <= ISSUE;
                end
                ISSUE: begin
                    tmo_cnt <= '0;
                    state   <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // A lost done pulse still commits so the game cannot stall.
                    if (cur_done || tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        if (!cur_done) err_timeout <= 1'b1;
                        if (current_player) p2_tile <= pend_tile;
                        else                p1_tile <= pend_tile;
                        state <= CHECK;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (cur_tile == 4'(NUM_TILES)) begin
                        winner_valid <= 1'b1;
                        winner_id    <= current_player;
                        state        <= GAME_OVER;
                    end else begin
                        current_player <= ~current_player;
                        state          <= IDLE;
                    end
                end
                GAME_OVER: state <= GAME_OVER;
                default:   state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/turn_manager.md
TURN_MANAGER -- requirements
Module: turn_manager

Interface
REQ-001 Parameter START_X, default 20: pixel x of tile 0.
REQ-002 Parameter TILE_SPACING, default 60: pixel distance between adjacent tiles.
REQ-003 Parameter NUM_TILES, default 10: index of the flag tile; x = START_X + TILE_SPACING*NUM_TILES = 620.
REQ-004 Parameter TIMEOUT_CYCLES, default 2**22: maximum wait for a turn_done response.
REQ-005 Reset is rst, asynchronous, active-high; the clock is clk.
REQ-006 Port clk, input, 1 bit: system clock.
REQ-007 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-008 Port roll_btn, input, 1 bit: level from the debounced roll button.
REQ-009 Port dice_value, input, 3 bits: RNG output, sampled on the roll edge.
REQ-010 Port p1_turn_done and p2_turn_done, input, 1 bit each: move-complete pulses from the player movement block.
REQ-011 Port p1_target_x and p2_target_x, output, 10 bits each: destination x per player.
REQ-012 Port p1_move_start and p2_move_start, output, 1 bit each: move request pulses.
REQ-013 Port p1_tile and p2_tile, output, 4 bits each: committed tile index per player.
REQ-014 Port current_player, output, 1 bit: 0 = player 1, 1 = player 2.
REQ-015 Port busy, output, 1 bit: high in every state except IDLE.
REQ-016 Port winner_valid, output, 1 bit, and winner_id, output, 1 bit: game result.
REQ-017 Port err_timeout and err_bad_dice, output, 1 bit each: sticky and pulse error flags respectively (REQ-025, REQ-027).

Function
REQ-018 The FSM SHALL have six states: IDLE, CALC, ISSUE, WAIT_DONE, CHECK, GAME_OVER.
REQ-019 Roll edge = roll_btn high and its value registered on the previous cycle low; edges outside IDLE are ignored and produce no side effects.
REQ-020 IDLE + roll edge + dice_value in 1..6: latch dice_value, go to CALC.
REQ-021 CALC: new_tile = min(tile[current_player] + dice, NUM_TILES), computed 5 bits wide before the clamp (no wrap); register the target_x of current_player = START_X + TILE_SPACING*new_tile; go to ISSUE.
REQ-022 ISSUE: lasts exactly 1 cycle. Assert move_start of current_player only, 2 cycles after the edge-detect cycle. Target_x is already stable during this cycle. Go to WAIT_DONE.
REQ-023 Target_x of each player SHALL hold its value until that player's next CALC.
REQ-024 WAIT_DONE: on turn_done of current_player, commit the tile and go to CHECK. turn_done of the other player, or any turn_done outside WAIT_DONE, is ignored.
REQ-025 WAIT_DONE: a timeout counter starts at 0 on entry. When it reaches TIMEOUT_CYCLES-1, set err_timeout (sticky), commit the tile and go to CHECK.
REQ-026 CHECK: if the committed tile == NUM_TILES, set winner_valid=1 and winner_id=current_player, go to GAME_OVER. Otherwise toggle current_player and go to IDLE.
REQ-027 IDLE + roll edge + dice_value 0 or 7: stay in IDLE and pulse err_bad_dice for 1 cycle.
REQ-028 GAME_OVER SHALL be absorbing (exit only by rst); all move_start outputs stay low and all inputs are ignored.
REQ-029 move_start outputs SHALL never be high for 2 consecutive cycles, and the two move_start outputs SHALL never be high together.
REQ-030 All outputs SHALL be registered or decoded directly from the state register; no input-to-output combinational path.

Reset
REQ-031 Reset values: state=IDLE, current_player=0, p1_tile=p2_tile=0, p1_target_x=p2_target_x=START_X.
REQ-032 Reset values: all move_start=0, busy=0, winner_valid=0, winner_id=0, err_timeout=0, err_bad_dice=0, edge register=0, timeout counter=0.
REQ-033 rst asserted mid-move SHALL abort the turn with no tile commit. The downstream movement block is reset by the same rst.

Structure
REQ-034 The state enum, START_X, TILE_SPACING, NUM_TILES and the flag x constant (620) SHALL live in shared package board_pkg, which the movement block also imports.
REQ-035 One sub-module SHALL be used: rise_edge_detect (1-bit registered rising-edge detector), instantiated for roll_btn.

Verification
REQ-036 Reset, roll with dice=3 -> p1_move_start is a 1-cycle pulse 2 cycles after the edge, p1_target_x=200. After p1_turn_done: p1_tile=3 and current_player=1, 2 cycles later.
REQ-037 p1_tile=8, roll with dice=5 -> p1_target_x=620 (clamped), then after turn_done: winner_valid=1, winner_id=0. A further roll gives no move_start.
REQ-038 Roll with dice=0, then dice=7 -> err_bad_dice pulses twice, state stays IDLE, current_player unchanged, no move_start.
REQ-039 Roll edges during WAIT_DONE, and p2_turn_done while player 1 is moving -> both ignored; only p1_turn_done advances the FSM.
REQ-040 TIMEOUT_CYCLES=16 and no turn_done -> err_timeout rises on the 16th WAIT_DONE cycle, the tile is committed and the turn passes. rst asserted during WAIT_DONE -> all REQ-031/REQ-032 values are restored.
